// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a two-entry skid buffer and a registered in_ready.
// The main register always drives out_data; the skid register catches the beat that
// arrives while downstream stalls and in_ready has not yet dropped.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             accept;
  logic             emit;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign count     = state_q;
  assign accept    = in_valid & in_ready_q;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        unique case ({accept, emit})
          2'b10: begin
            state_d = FULL;
            skid_d  = in_data;
          end
          2'b01: state_d = EMPTY;
          2'b11: main_d = in_data;
          default: ;
        endcase
      end
      FULL: begin
        if (emit) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A flush discards everything, including a beat transferred on this same edge.
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end
  end

  // in_ready is precomputed from the next state so it never depends on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

endmodule
